// File: rtl/ps2_key_tracker.sv
// PS/2 key-state tracker: decodes make/break/E0 scan-code sequences into per-key
// held levels, one-cycle press/release pulses and a queued event stream.
module ps2_key_slot (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic set,
  input  logic clr,
  output logic down,
  output logic press,
  output logic rel
);
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      down  <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= set & ~down;
      rel   <= clr & down;
      if (set)      down <= 1'b1;
      else if (clr) down <= 1'b0;
    end
  end
endmodule

module ps2_key_tracker #(
  parameter int NUM_KEYS   = 15,
  parameter logic [9*NUM_KEYS-1:0] KEY_CODES = {
    9'h174, 9'h16B, 9'h172, 9'h175, 9'h076, 9'h029, 9'h05A, 9'h04B,
    9'h042, 9'h03B, 9'h043, 9'h023, 9'h01B, 9'h01C, 9'h01D},
  parameter int FIFO_DEPTH = 8,
  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [7:0]          rx_data,
  input  logic                rx_en,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                any_key,
  output logic                evt_valid,
  output logic [IDX_W-1:0]    evt_key,
  output logic                evt_break,
  input  logic                evt_ready,
  output logic                evt_overflow,
  input  logic                clr_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  state_t state, nxt;

  logic res, brk, ext;
  always_comb begin
    nxt = state;
    res = 1'b0;
    brk = 1'b0;
    ext = 1'b0;
    if (rx_en) begin
      if (rx_data == 8'hE1) nxt = IDLE;
      else begin
        case (state)
          IDLE: begin
            if (rx_data == 8'hE0)      nxt = EXT;
            else if (rx_data == 8'hF0) nxt = BRK;
            else                       res = 1'b1;
          end
          EXT: begin
            if (rx_data == 8'hF0)      nxt = EXT_BRK;
            else if (rx_data != 8'hE0) begin
              res = 1'b1;
              ext = 1'b1;
              nxt = IDLE;
            end
          end
          default: begin
            // a second prefix after F0 is malformed: drop the whole sequence
            nxt = IDLE;
            brk = 1'b1;
            ext = (state == EXT_BRK);
            res = (rx_data != 8'hE0) && (rx_data != 8'hF0);
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= nxt;
  end

  logic [NUM_KEYS-1:0] hit;
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_hit
    assign hit[g] = (KEY_CODES[9*g +: 9] == {ext, rx_data});
  end

  logic             found;
  logic [IDX_W-1:0] idx;
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

  logic                cur_down, push;
  logic [NUM_KEYS-1:0] set_vec, clr_vec, onehot;
  assign cur_down = key_down[idx];
  assign onehot   = NUM_KEYS'(1) << idx;
  assign set_vec  = (res && found && !brk && !cur_down) ? onehot : '0;
  assign clr_vec  = (res && found &&  brk &&  cur_down) ? onehot : '0;
  assign push     = |(set_vec | clr_vec);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_slot
    ps2_key_slot u_slot (
      .CLOCK_50 (CLOCK_50),
      .resetn   (resetn),
      .set      (set_vec[g]),
      .clr      (clr_vec[g]),
      .down     (key_down[g]),
      .press    (key_press[g]),
      .rel      (key_release[g])
    );
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) any_key <= 1'b0;
    else         any_key <= |((key_down | set_vec) & ~clr_vec);
  end

  // event FIFO: extra pointer MSB distinguishes full from empty
  logic [IDX_W:0] mem [FIFO_DEPTH];
  logic [AW:0]    wp, rp;
  logic           empty, full, pop, do_push;
  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop     = evt_ready && !empty;
  assign do_push = push && (!full || pop);

  always_ff @(posedge CLOCK_50) begin
    if (do_push) mem[wp[AW-1:0]] <= {idx, brk};
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      wp           <= '0;
      rp           <= '0;
      evt_overflow <= 1'b0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (pop)     rp <= rp + 1'b1;
      if (push && full && !pop) evt_overflow <= 1'b1;
      else if (clr_overflow)    evt_overflow <= 1'b0;
    end
  end

  assign evt_valid = !empty;
  assign evt_key   = mem[rp[AW-1:0]][IDX_W:1];
  assign evt_break = mem[rp[AW-1:0]][0];
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: scan-code sequences with hand-derived key states and events.
module tb_ps2_key_tracker;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_en = 1'b0;
  logic [14:0] key_down, key_press, key_release;
  logic        any_key, evt_valid, evt_break, evt_overflow;
  logic [3:0]  evt_key;
  logic        evt_ready = 1'b0;
  logic        clr_overflow = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          cnt_p, cnt_r;

  always #5 clk = ~clk;

  ps2_key_tracker dut (
    .CLOCK_50     (clk),
    .resetn       (resetn),
    .rx_data      (rx_data),
    .rx_en        (rx_en),
    .key_down     (key_down),
    .key_press    (key_press),
    .key_release  (key_release),
    .any_key      (any_key),
    .evt_valid    (evt_valid),
    .evt_key      (evt_key),
    .evt_break    (evt_break),
    .evt_ready    (evt_ready),
    .evt_overflow (evt_overflow),
    .clr_overflow (clr_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // drive one byte for one cycle; returns at the negedge after the capturing edge
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_en   = 1'b1;
    @(negedge clk);
    rx_en   = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input int k, input logic b);
    chk({tag, "_valid"}, evt_valid, 1);
    chk({tag, "_key"},   evt_key, k);
    chk({tag, "_brk"},   evt_break, b);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #3;
    chk("rst_down",  key_down, 0);
    chk("rst_any",   any_key, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_ovf",   evt_overflow, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // press and release W
    send(8'h1D);
    chk("w_down",  key_down, 15'h0001);
    chk("w_press", key_press, 15'h0001);
    chk("w_any",   any_key, 1);
    chk("w_valid", evt_valid, 1);
    @(negedge clk);
    chk("w_press_once", key_press, 0);
    send(8'hF0);
    send(8'h1D);
    chk("w_up",  key_down, 0);
    chk("w_rel", key_release, 15'h0001);
    chk("w_any0", any_key, 0);
    @(negedge clk);
    chk("w_rel_once", key_release, 0);
    pop_chk("w_ev0", 0, 1'b0);
    pop_chk("w_ev1", 0, 1'b1);
    chk("w_empty", evt_valid, 0);

    // extended Up arrow; bare 75 must not alias it
    send(8'hE0);
    send(8'h75);
    chk("up_down", key_down, 15'h0800);
    send(8'h75);
    chk("bare75_down",  key_down, 15'h0800);
    chk("bare75_press", key_press, 0);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("up_clr", key_down, 0);
    chk("up_rel", key_release, 15'h0800);
    pop_chk("up_ev0", 11, 1'b0);
    pop_chk("up_ev1", 11, 1'b1);
    chk("up_empty", evt_valid, 0);

    // typematic repeat on A
    cnt_p = 0;
    cnt_r = 0;
    for (int i = 0; i < 3; i++) begin
      send(8'h1C);
      cnt_p += $countones(key_press);
    end
    send(8'hF0);
    cnt_r += $countones(key_release);
    send(8'h1C);
    cnt_r += $countones(key_release);
    chk("rep_press", cnt_p, 1);
    chk("rep_rel",   cnt_r, 1);
    pop_chk("rep_ev0", 1, 1'b0);
    pop_chk("rep_ev1", 1, 1'b1);
    chk("rep_empty", evt_valid, 0);

    // overflow: 9 makes into an 8-deep queue
    send(8'h1D); send(8'h1C); send(8'h1B); send(8'h23); send(8'h43);
    send(8'h3B); send(8'h42); send(8'h4B);
    chk("ovf_not_yet", evt_overflow, 0);
    send(8'h5A);
    chk("ovf_down",  key_down, 15'h01FF);
    chk("ovf_press", key_press, 15'h0100);
    chk("ovf_flag",  evt_overflow, 1);
    chk("ovf_head",  evt_key, 0);
    // simultaneous pop and push (Space) while full
    evt_ready = 1'b1;
    rx_data   = 8'h29;
    rx_en     = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    rx_en     = 1'b0;
    chk("ovf_space_down", key_down, 15'h03FF);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    chk("ovf_clr", evt_overflow, 0);
    for (int k = 1; k < 8; k++) pop_chk("ovf_drain", k, 1'b0);
    pop_chk("ovf_last", 9, 1'b0);
    chk("ovf_empty", evt_valid, 0);
    do_reset();

    // malformed prefixes and an unmapped code
    send(8'hF0); send(8'hF0); send(8'h1D);
    chk("mal_make", key_down, 15'h0001);
    chk("mal_norel", key_release, 0);
    send(8'hF0); send(8'h1D);
    chk("mal_rel", key_down, 0);
    send(8'hF0); send(8'hE1); send(8'h1D);
    chk("e1_make",  key_down, 15'h0001);
    chk("e1_press", key_press, 15'h0001);
    send(8'h15);
    chk("unk_down",  key_down, 15'h0001);
    chk("unk_press", key_press, 0);
    pop_chk("mal_ev0", 0, 1'b0);
    pop_chk("mal_ev1", 0, 1'b1);
    pop_chk("mal_ev2", 0, 1'b0);
    chk("mal_empty", evt_valid, 0);

    // reset after a partial E0 F0 prefix
    send(8'hE0);
    send(8'hF0);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_down",  key_down, 0);
    chk("mid_press", key_press, 0);
    chk("mid_rel",   key_release, 0);
    chk("mid_any",   any_key, 0);
    chk("mid_valid", evt_valid, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    send(8'h75);
    chk("post_down",  key_down, 0);
    chk("post_rel",   key_release, 0);
    chk("post_valid", evt_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
